aligned_pp_pipe: RTL and testbench
==================================

ALIGNED_PP_PIPE -- requirements
Module: aligned_pp_pipe

Interface
REQ-001 Parameter NUM_PP, default 9, number of partial-product channels (1..16).
REQ-002 Parameter PP_W, default 16, bit width of each channel (4..32).
REQ-003 Parameter DEPTH, default 2, number of register stages (1..8).
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port flush  input  1  discards all in-flight beats.
REQ-007 Port in_valid  input  1  upstream beat present.
REQ-008 Port in_ready  output  1  block accepts a beat this cycle.
REQ-009 Port in_data  input  NUM_PP*PP_W  channel k occupies bits [k*PP_W +: PP_W].
REQ-010 Port out_valid  output  1  the last stage holds a beat.
REQ-011 Port out_ready  input  1  downstream accepts a beat.
REQ-012 Port out_data  output  NUM_PP*PP_W  same packing as in_data.
REQ-013 Port occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Stage i holds a valid bit v[i] and a data register d[i]; stage 0 is the input stage and stage DEPTH-1 drives out_valid and out_data.
REQ-015 Stage i advances when v[i]=1 and its consumer accepts; the consumer is out_ready for the last stage and the load condition of stage i+1 otherwise.
REQ-016 Stage i loads when flush=0 and (v[i]=0 or stage i advances).
REQ-017 in_ready = load condition of stage 0; it is combinational from out_ready through the ready chain, and no combinational path exists from in_valid to in_ready.
REQ-018 On a load, d[i] takes the upstream data and v[i] takes the upstream valid.
REQ-019 d[i] holds its value when the stage does not load; when v[i]=0, d[i] contents are don't-care.
REQ-020 Bubbles collapse: an empty stage loads even when downstream is stalled.
REQ-021 With no stall, latency from in_valid&in_ready to out_valid is exactly DEPTH cycles, throughput is 1 beat per cycle, and beat order is preserved.
REQ-022 An input beat is transferred iff in_valid&in_ready; an output beat is transferred iff out_valid&out_ready.
REQ-023 Data bits pass through unmodified; there is no arithmetic and no loss of width.
REQ-024 Flush: in_ready=0 in the flush cycle; all v[i]=0 on the next edge; an out_valid&out_ready transfer in the flush cycle still counts as delivered.
REQ-025 Flush held for multiple cycles keeps the pipe empty; normal operation resumes the cycle after flush deasserts.
REQ-026 occupancy is registered and equals the popcount of v[] at all times.
REQ-027 Full (occupancy=DEPTH) with out_ready=0: in_ready=0 and no data register changes.
REQ-028 Full with out_ready=1: a simultaneous input and output transfer leaves occupancy unchanged.

Reset
REQ-029 When rst=1 at a clock edge, all v[i], all d[i] and occupancy clear to 0, so out_valid=0 and out_data=0 after reset.
REQ-030 rst has priority over flush and over any handshake; beats in flight at reset are lost.
REQ-031 While rst=1, in_ready is forced to 0.

Structure
REQ-032 Package aligned_pp_pkg holds the default constants NUM_PP_DEF=9, PP_W_DEF=16 and DEPTH_DEF=2, plus the packed bus-width function NUM_PP*PP_W.
REQ-033 Sub-module aligned_pp_stage implements one elastic stage (v, d, load/advance logic) with a parameterised data width; the top instantiates it DEPTH times in a generate loop and adds the occupancy counter.

Verification
REQ-034 The bench shall run with NUM_PP=9, PP_W=16, DEPTH=2 unless stated otherwise, and shall cover the following scenarios.
REQ-035 Streaming: out_ready=1, send beats 0x0001..0x0009 per channel, 10 beats back-to-back -> out_valid rises 2 cycles after the first accept, all 10 beats arrive in order, and in_ready stays 1.
REQ-036 Stall: fill the pipe, then out_ready=0 for 5 cycles -> occupancy=2, in_ready=0, out_data stable; release -> no beat lost or duplicated.
REQ-037 Bubble collapse: one beat, out_ready=0 -> the beat reaches stage 1; a second beat is accepted and occupancy=2.
REQ-038 Flush with occupancy=2 and out_ready=1 in the flush cycle -> exactly one beat is delivered, then occupancy=0 and out_valid=0 on the next cycle.
REQ-039 Reset mid-stream with occupancy=2 -> out_valid=0, out_data=0 and occupancy=0 on the next cycle, and in_ready=0 while rst=1.
REQ-040 Random valid/ready at 50% each for 10k beats at DEPTH=1 and DEPTH=8 -> output sequence equals input sequence against a scoreboard.

Source files
------------

// File: rtl/aligned_pp_pkg.sv
// Shared defaults and bus-width helper for the aligned partial-product pipe.
package aligned_pp_pkg;

  localparam int NUM_PP_DEF = 9;
  localparam int PP_W_DEF   = 16;
  localparam int DEPTH_DEF  = 2;

  // Packed width of all partial-product channels side by side.
  function automatic int bus_w(input int num_pp, input int pp_w);
    return num_pp * pp_w;
  endfunction

endpackage

// File: rtl/aligned_pp_pipe_if.sv
// Handshake bundle for the aligned partial-product pipe: input and output
// valid/ready channels, flush and the occupancy status.
interface aligned_pp_pipe_if
  import aligned_pp_pkg::*;
#(
  parameter int NUM_PP = NUM_PP_DEF,
  parameter int PP_W   = PP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int BUS_W = bus_w(NUM_PP, PP_W);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  // Producer/consumer side that talks to the pipe.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  // The pipe itself.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

endinterface

// File: rtl/aligned_pp_stage.sv
// One elastic register stage: a valid bit plus a data word. The stage loads
// whenever it is empty or its contents are being taken downstream, so bubbles
// collapse even while the output is stalled.
module aligned_pp_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         up_valid_i,
  input  logic [W-1:0] up_data_i,
  input  logic         dn_ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;
  logic         load;

  // Load when empty or advancing; flush empties the stage without touching data.
  always_comb begin
    load = ~flush_i & (~v_q | dn_ready_i);
    v_d  = v_q;
    d_d  = d_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (load) begin
      v_d = up_valid_i;
      d_d = up_data_i;
    end
  end

  // Stage registers; reset also clears the data so out_data reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;

endmodule

// File: rtl/aligned_pp_pipe.sv
// Elastic pipeline of DEPTH stages carrying NUM_PP partial products unchanged.
// The ready chain is combinational from out_ready; in_valid never feeds ready.
module aligned_pp_pipe
  import aligned_pp_pkg::*;
#(
  parameter int NUM_PP = NUM_PP_DEF,
  parameter int PP_W   = PP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic              clk,
  input logic              rst,
  aligned_pp_pipe_if.slave bus
);

  localparam int BUS_W = bus_w(NUM_PP, PP_W);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [BUS_W-1:0] d [DEPTH];
  logic [DEPTH-1:0] dn_rdy;
  logic             rdy_acc;
  logic             in_rdy;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Ready chain: stage i's consumer accepts if out_ready or any later stage is
  // empty. Accumulated from the output end so no signal feeds back on itself.
  always_comb begin
    dn_rdy  = '0;
    rdy_acc = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      dn_rdy[i] = rdy_acc;
      rdy_acc   = rdy_acc | ~v[i];
    end
    in_rdy = rdy_acc & ~bus.flush & ~rst;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [BUS_W-1:0] up_d;

    if (i == 0) begin : g_first
      assign up_v = bus.in_valid;
      assign up_d = bus.in_data;
    end else begin : g_next
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end

    aligned_pp_stage #(
      .W(BUS_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (bus.flush),
      .up_valid_i(up_v),
      .up_data_i (up_d),
      .dn_ready_i(dn_rdy[i]),
      .valid_o   (v[i]),
      .data_o    (d[i])
    );
  end

  assign in_xfer  = bus.in_valid & in_rdy;
  assign out_xfer = v[DEPTH-1] & bus.out_ready;

  // Beats in flight: +1 per accepted input, -1 per delivered output.
  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  // Registered occupancy so it tracks the stage valid bits exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_aligned_pp_pipe.sv
// Bench for aligned_pp_pipe: directed scenarios on a DEPTH=2 instance and
// randomized valid/ready traffic on DEPTH=1 and DEPTH=8 instances, checked
// against a FIFO-style reference (beats in flight kept in a queue).
module tb_aligned_pp_pipe;

  localparam int NPP     = 9;
  localparam int PW      = 16;
  localparam int BW      = NPP * PW;
  localparam int N_BEATS = 10000;
  localparam int BUDGET  = 40000;

  typedef logic [BW-1:0] word_t;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  word_t q1[$];
  word_t q8[$];
  int    sent1, got1, cyc1;
  int    sent8, got8, cyc8;
  int    exp_acc, exp_del;

  aligned_pp_pipe_if #(.NUM_PP(NPP), .PP_W(PW), .DEPTH(2)) bus2 ();
  aligned_pp_pipe_if #(.NUM_PP(NPP), .PP_W(PW), .DEPTH(1)) bus1 ();
  aligned_pp_pipe_if #(.NUM_PP(NPP), .PP_W(PW), .DEPTH(8)) bus8 ();

  aligned_pp_pipe #(.NUM_PP(NPP), .PP_W(PW), .DEPTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  aligned_pp_pipe #(.NUM_PP(NPP), .PP_W(PW), .DEPTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  aligned_pp_pipe #(.NUM_PP(NPP), .PP_W(PW), .DEPTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t beat_of(input int n);
    word_t r;
    for (int k = 0; k < NPP; k++) r[k*PW +: PW] = PW'((n << 8) + k + 1);
    return r;
  endfunction

  function automatic word_t rand_beat();
    word_t r;
    for (int k = 0; k < NPP; k++) r[k*PW +: PW] = PW'($urandom);
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus8.flush = 1'b0; bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;

    // Reset state
    repeat (3) next_cycle();
    bus2.in_valid = 1'b1;
    bus2.in_data  = beat_of(99);
    bus2.out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", word_t'(bus2.in_ready), 0);
    check_eq("rst_out_valid", word_t'(bus2.out_valid), 0);
    check_eq("rst_out_data", bus2.out_data, 0);
    check_eq("rst_occ", word_t'(bus2.occupancy), 0);
    check_eq("rst_occ_d1", word_t'(bus1.occupancy), 0);
    check_eq("rst_occ_d8", word_t'(bus8.occupancy), 0);
    next_cycle();
    bus2.in_valid = 1'b0;
    rst = 1'b0;
    next_cycle();

    // Streaming: 10 back-to-back beats, out_ready held high
    for (int c = 0; c < 14; c++) begin
      bus2.in_valid  = (c < 10);
      bus2.in_data   = beat_of(c);
      bus2.out_ready = 1'b1;
      #1;
      exp_acc = (c < 10) ? c : 10;
      exp_del = (c > 2) ? (((c < 12) ? c : 12) - 2) : 0;
      if (c < 10) check_eq("stream_in_ready", word_t'(bus2.in_ready), 1);
      check_eq("stream_out_valid", word_t'(bus2.out_valid), word_t'((c >= 2) && (c < 12)));
      check_eq("stream_occ", word_t'(bus2.occupancy), word_t'(exp_acc - exp_del));
      if (c >= 2 && c < 12) check_eq("stream_out_data", bus2.out_data, beat_of(c - 2));
      next_cycle();
    end

    // Stall: fill, hold out_ready low, then release
    bus2.out_ready = 1'b0;
    bus2.in_valid = 1'b1; bus2.in_data = beat_of(20); #1;
    check_eq("stall_fill0_ready", word_t'(bus2.in_ready), 1);
    next_cycle();
    bus2.in_data = beat_of(21); #1;
    check_eq("stall_fill1_ready", word_t'(bus2.in_ready), 1);
    next_cycle();
    for (int s = 0; s < 5; s++) begin
      bus2.in_data = beat_of(22); #1;
      check_eq("stall_in_ready", word_t'(bus2.in_ready), 0);
      check_eq("stall_occ", word_t'(bus2.occupancy), 2);
      check_eq("stall_out_data", bus2.out_data, beat_of(20));
      next_cycle();
    end
    bus2.out_ready = 1'b1; #1;
    check_eq("release_in_ready", word_t'(bus2.in_ready), 1);
    check_eq("release_out_data0", bus2.out_data, beat_of(20));
    next_cycle();
    bus2.in_valid = 1'b0; #1;
    check_eq("release_occ_same", word_t'(bus2.occupancy), 2);
    check_eq("release_out_data1", bus2.out_data, beat_of(21));
    next_cycle();
    check_eq("release_out_data2", bus2.out_data, beat_of(22));
    check_eq("release_occ1", word_t'(bus2.occupancy), 1);
    next_cycle();
    check_eq("release_empty", word_t'(bus2.out_valid), 0);
    check_eq("release_occ0", word_t'(bus2.occupancy), 0);

    // Bubble collapse with output stalled
    bus2.out_ready = 1'b0;
    bus2.in_valid = 1'b1; bus2.in_data = beat_of(30); #1;
    check_eq("bubble_in_ready0", word_t'(bus2.in_ready), 1);
    next_cycle();
    bus2.in_valid = 1'b0; #1;
    check_eq("bubble_occ1", word_t'(bus2.occupancy), 1);
    check_eq("bubble_out_valid0", word_t'(bus2.out_valid), 0);
    next_cycle();
    check_eq("bubble_reached_last", word_t'(bus2.out_valid), 1);
    check_eq("bubble_out_data", bus2.out_data, beat_of(30));
    bus2.in_valid = 1'b1; bus2.in_data = beat_of(31); #1;
    check_eq("bubble_in_ready1", word_t'(bus2.in_ready), 1);
    next_cycle();
    bus2.in_valid = 1'b0; #1;
    check_eq("bubble_occ2", word_t'(bus2.occupancy), 2);

    // Flush with a full pipe and out_ready high: one beat still delivered
    bus2.flush = 1'b1; bus2.out_ready = 1'b1;
    bus2.in_valid = 1'b1; bus2.in_data = beat_of(32); #1;
    check_eq("flush_in_ready", word_t'(bus2.in_ready), 0);
    check_eq("flush_out_valid", word_t'(bus2.out_valid), 1);
    check_eq("flush_out_data", bus2.out_data, beat_of(30));
    next_cycle();
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; #1;
    check_eq("flush_occ", word_t'(bus2.occupancy), 0);
    check_eq("flush_out_valid_after", word_t'(bus2.out_valid), 0);
    next_cycle();
    check_eq("flush_no_leftover", word_t'(bus2.out_valid), 0);

    // Flush held several cycles, then resume
    bus2.flush = 1'b1; bus2.in_valid = 1'b1; bus2.in_data = beat_of(40);
    for (int f = 0; f < 3; f++) begin
      #1;
      check_eq("hold_flush_in_ready", word_t'(bus2.in_ready), 0);
      check_eq("hold_flush_occ", word_t'(bus2.occupancy), 0);
      next_cycle();
    end
    bus2.flush = 1'b0; #1;
    check_eq("resume_in_ready", word_t'(bus2.in_ready), 1);
    next_cycle();
    bus2.in_valid = 1'b0;
    next_cycle();
    check_eq("resume_out_valid", word_t'(bus2.out_valid), 1);
    check_eq("resume_out_data", bus2.out_data, beat_of(40));
    next_cycle();
    check_eq("resume_drained", word_t'(bus2.out_valid), 0);

    // Reset mid-stream with a full pipe
    bus2.out_ready = 1'b0;
    bus2.in_valid = 1'b1; bus2.in_data = beat_of(50);
    next_cycle();
    bus2.in_data = beat_of(51);
    next_cycle();
    bus2.in_valid = 1'b0; #1;
    check_eq("midrst_occ_before", word_t'(bus2.occupancy), 2);
    rst = 1'b1; bus2.in_valid = 1'b1; bus2.out_ready = 1'b1; #1;
    check_eq("midrst_in_ready", word_t'(bus2.in_ready), 0);
    next_cycle();
    check_eq("midrst_out_valid", word_t'(bus2.out_valid), 0);
    check_eq("midrst_out_data", bus2.out_data, 0);
    check_eq("midrst_occ", word_t'(bus2.occupancy), 0);
    check_eq("midrst_in_ready_held", word_t'(bus2.in_ready), 0);
    rst = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    next_cycle();

    // Random traffic against a queue of in-flight beats
    sent1 = 0; got1 = 0; cyc1 = 0;
    sent8 = 0; got8 = 0; cyc8 = 0;
    fork
      begin : rnd_d1
        while ((sent1 < N_BEATS || q1.size() != 0) && cyc1 < BUDGET) begin
          @(negedge clk);
          bus1.in_valid  = (sent1 < N_BEATS) && ($urandom_range(1, 0) == 1);
          bus1.in_data   = rand_beat();
          bus1.out_ready = ($urandom_range(1, 0) == 1);
          #1;
          check_eq("rnd1_occ", word_t'(bus1.occupancy), word_t'(q1.size()));
          check_eq("rnd1_in_ready", word_t'(bus1.in_ready),
                   word_t'(!(q1.size() == 1 && !bus1.out_ready)));
          if (bus1.out_valid) begin
            if (q1.size() == 0) begin
              check_eq("rnd1_valid_when_empty", word_t'(bus1.out_valid), 0);
            end else begin
              check_eq("rnd1_data", bus1.out_data, q1[0]);
              if (bus1.out_ready) begin
                void'(q1.pop_front());
                got1++;
              end
            end
          end
          if (bus1.in_valid && bus1.in_ready) begin
            q1.push_back(bus1.in_data);
            sent1++;
          end
          cyc1++;
        end
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b0;
        check_eq("rnd1_delivered", word_t'(got1), N_BEATS);
      end
      begin : rnd_d8
        while ((sent8 < N_BEATS || q8.size() != 0) && cyc8 < BUDGET) begin
          @(negedge clk);
          bus8.in_valid  = (sent8 < N_BEATS) && ($urandom_range(1, 0) == 1);
          bus8.in_data   = rand_beat();
          bus8.out_ready = ($urandom_range(1, 0) == 1);
          #1;
          check_eq("rnd8_occ", word_t'(bus8.occupancy), word_t'(q8.size()));
          check_eq("rnd8_in_ready", word_t'(bus8.in_ready),
                   word_t'(!(q8.size() == 8 && !bus8.out_ready)));
          if (bus8.out_valid) begin
            if (q8.size() == 0) begin
              check_eq("rnd8_valid_when_empty", word_t'(bus8.out_valid), 0);
            end else begin
              check_eq("rnd8_data", bus8.out_data, q8[0]);
              if (bus8.out_ready) begin
                void'(q8.pop_front());
                got8++;
              end
            end
          end
          if (bus8.in_valid && bus8.in_ready) begin
            q8.push_back(bus8.in_data);
            sent8++;
          end
          cyc8++;
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b0;
        check_eq("rnd8_delivered", word_t'(got8), N_BEATS);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
